// File: rtl/polirv_pkg.sv
// Shared types and constants for the polirv data-memory responder.
package polirv_pkg;

  localparam int DMEM_DATA_W  = 64;
  localparam int DMEM_MAX_LAT = 4;
  localparam int DMEM_CNT_W   = $clog2(DMEM_MAX_LAT + 1);

  typedef enum logic {
    DMEM_CLEAR,
    DMEM_SERVE
  } dmem_state_t;

endpackage

// File: rtl/polirv_dmem_rdpipe.sv
// Read path of the data memory: READ_LAT-deep data pipeline plus the
// saturating latency counter that restarts on any address or write change.
module polirv_dmem_rdpipe
  import polirv_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   serve,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DMEM_DATA_W-1:0] mem_word,
  output logic [DMEM_DATA_W-1:0] rdata,
  output logic                   rvalid
);

  localparam logic [DMEM_CNT_W-1:0] LAT_TOP = DMEM_CNT_W'(READ_LAT);

  logic [ADDR_W-1:0]      addr_q;
  logic                   we_q;
  logic [DMEM_CNT_W-1:0]  cnt_q;
  logic [DMEM_CNT_W-1:0]  lat_cnt;
  logic                   restart;
  logic [DMEM_DATA_W-1:0] stage [READ_LAT];

  // The restart is seen in the same cycle the address moves, so rvalid
  // drops immediately instead of one edge late.
  // NOTE: every always_comb output gets a value on every path, which keeps
  // the block free of inferred latches.
  always_comb begin
    restart = (addr_q != addr) || we_q || !serve;
    lat_cnt = restart ? '0 : cnt_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr;
      we_q   <= we;
      if (!serve)
        cnt_q <= '0;
      else if (lat_cnt != LAT_TOP)
        cnt_q <= lat_cnt + 1'b1;
      else
        cnt_q <= lat_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= mem_word;
      for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign rdata  = stage[READ_LAT-1];
  assign rvalid = (lat_cnt == LAT_TOP) && !we && serve;

endmodule

// File: rtl/polirv_dmem.sv
// Data-memory responder on the polirv d_mem tri-state bus. Optional
// post-reset zeroing sweep is built when POLIRV_DMEM_CLEAR_EN is defined.
module polirv_dmem
  import polirv_pkg::*;
#(
  parameter int d_addr_bits = 6,
  parameter int READ_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   d_mem_we,
  input  logic [d_addr_bits-1:0] d_mem_addr,
  inout  wire  [DMEM_DATA_W-1:0] d_mem_data,
  output logic                   d_mem_rvalid,
  output logic                   d_mem_busy
);

  localparam int DEPTH = 2 ** d_addr_bits;

  if (READ_LAT < 1 || READ_LAT > DMEM_MAX_LAT) begin : g_bad_read_lat
    $error("polirv_dmem: READ_LAT must be within 1..%0d", DMEM_MAX_LAT);
  end

  dmem_state_t            state;
  logic [DMEM_DATA_W-1:0] mem [DEPTH];
  logic [DMEM_DATA_W-1:0] rd_data;
  logic                   rd_valid;
  logic                   serve;

`ifdef POLIRV_DMEM_CLEAR_EN
  dmem_state_t            state_nxt;
  logic [d_addr_bits-1:0] clr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DMEM_CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == DMEM_CLEAR) clr_ptr <= clr_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == DMEM_CLEAR && clr_ptr == '1) state_nxt = DMEM_SERVE;
  end

  assign d_mem_busy = (state == DMEM_CLEAR);

  // NOTE: the storage array has no reset; zeroing, when wanted, is done by
  // the sweep one word per cycle so the array still maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == DMEM_CLEAR)
      mem[clr_ptr] <= '0;
    else if (d_mem_we)
      mem[d_mem_addr] <= d_mem_data;
  end
`else
  assign state      = DMEM_SERVE;
  assign d_mem_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (d_mem_we) mem[d_mem_addr] <= d_mem_data;
  end
`endif

  assign serve = (state == DMEM_SERVE);

  polirv_dmem_rdpipe #(
    .ADDR_W   (d_addr_bits),
    .READ_LAT (READ_LAT)
  ) u_rdpipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .serve    (serve),
    .we       (d_mem_we),
    .addr     (d_mem_addr),
    .mem_word (mem[d_mem_addr]),
    .rdata    (rd_data),
    .rvalid   (rd_valid)
  );

  // Enable is gated by ~d_mem_we directly so the block can never fight the
  // core, even in the cycle the core starts a write.
  assign d_mem_data   = (rd_valid && !d_mem_we) ? rd_data : 'z;
  assign d_mem_rvalid = rd_valid;

endmodule

// File: tb/tb_polirv_dmem.sv
// Directed bench for polirv_dmem: one instance with READ_LAT=1, one with 3.
// The bus nets are pulled up, so a released bus reads as all ones.
module tb_polirv_dmem;
  import polirv_pkg::*;

  localparam int AW = 6;
  localparam logic [63:0] BUS_IDLE = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef POLIRV_DMEM_CLEAR_EN
  localparam logic EXP_BUSY = 1'b1;
`else
  localparam logic EXP_BUSY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [63:0]   drv_a, drv_b;
  logic          den_a, den_b;
  logic          rvalid_a, rvalid_b, busy_a, busy_b;
  tri1  [63:0]   bus_a, bus_b;

  assign bus_a = den_a ? drv_a : 'z;
  assign bus_b = den_b ? drv_b : 'z;

  polirv_dmem #(.d_addr_bits(AW), .READ_LAT(1)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_mem_we     (we_a),
    .d_mem_addr   (addr_a),
    .d_mem_data   (bus_a),
    .d_mem_rvalid (rvalid_a),
    .d_mem_busy   (busy_a)
  );

  polirv_dmem #(.d_addr_bits(AW), .READ_LAT(3)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_mem_we     (we_b),
    .d_mem_addr   (addr_b),
    .d_mem_data   (bus_b),
    .d_mem_rvalid (rvalid_b),
    .d_mem_busy   (busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int   cycles;
    logic clear_ok;
    we_a = 1'b0; addr_a = '0; drv_a = '0; den_a = 1'b0;
    we_b = 1'b0; addr_b = '0; drv_b = '0; den_b = 1'b0;
    tick(2);

    check("rst_rvalid_a", 64'(rvalid_a), 64'd0);
    check("rst_bus_a",    bus_a,         BUS_IDLE);
    check("rst_rvalid_b", 64'(rvalid_b), 64'd0);
    check("rst_busy_a",   64'(busy_a),   64'(EXP_BUSY));

`ifdef POLIRV_DMEM_CLEAR_EN
    // Core attempts a write to addr 10 on dut_b while the sweep runs.
    addr_a = 6'd5;
    we_b = 1'b1; addr_b = 6'd10; drv_b = 64'h55; den_b = 1'b1;
    rst_n = 1'b1;
    cycles = 0;
    clear_ok = 1'b1;
    while (busy_a === 1'b1 && cycles < 100) begin
      tick(1);
      cycles++;
      if (cycles == 5) begin
        we_b = 1'b0; den_b = 1'b0;
      end
      if (busy_a === 1'b1 && (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || bus_a !== BUS_IDLE))
        clear_ok = 1'b0;
    end
    check("clear_cycles", 64'(cycles),   64'd64);
    check("clear_quiet",  64'(clear_ok), 64'd1);
    check("clear_busy_b", 64'(busy_b),   64'd0);

    check("clr_rd5_wait",  64'(rvalid_a), 64'd0);
    tick(1);
    check("clr_rd5_valid", 64'(rvalid_a), 64'd1);
    check("clr_rd5_data",  bus_a,         64'd0);
    check("clr_rd10_wait", 64'(rvalid_b), 64'd0);
    tick(2);
    check("clr_rd10_valid", 64'(rvalid_b), 64'd1);
    check("clr_rd10_data",  bus_b,         64'd0);
`else
    rst_n = 1'b1;
    tick(1);
    check("busy_tied_a", 64'(busy_a), 64'd0);
`endif

    // Write then read back on the READ_LAT=1 instance.
    we_a = 1'b1; addr_a = 6'd3; drv_a = 64'hDEADBEEF_CAFEF00D; den_a = 1'b1;
    #1;
    check("wr_rvalid_a", 64'(rvalid_a), 64'd0);
    check("wr_bus_a",    bus_a,         64'hDEADBEEF_CAFEF00D);
    tick(1);
    we_a = 1'b0; den_a = 1'b0;
    #1;
    check("rd3_restart_a", 64'(rvalid_a), 64'd0);
    check("rd3_bus_rel_a", bus_a,         BUS_IDLE);
    tick(1);
    check("rd3_valid_a", 64'(rvalid_a), 64'd1);
    check("rd3_data_a",  bus_a,         64'hDEADBEEF_CAFEF00D);

    // Latency on the READ_LAT=3 instance.
    we_b = 1'b1; addr_b = 6'd3; drv_b = 64'h11; den_b = 1'b1;
    tick(1);
    addr_b = 6'd7; drv_b = 64'h77;
    tick(1);
    we_b = 1'b0; den_b = 1'b0; addr_b = 6'd3;
    tick(3);
    check("lat_rd3_valid", 64'(rvalid_b), 64'd1);
    check("lat_rd3_data",  bus_b,         64'h11);
    addr_b = 6'd7;
    #1;
    check("lat_sw_c0_rv",  64'(rvalid_b), 64'd0);
    check("lat_sw_c0_bus", bus_b,         BUS_IDLE);
    tick(1);
    check("lat_sw_c1_rv",  64'(rvalid_b), 64'd0);
    check("lat_sw_c1_bus", bus_b,         BUS_IDLE);
    tick(1);
    check("lat_sw_c2_rv",  64'(rvalid_b), 64'd0);
    tick(1);
    check("lat_rd7_valid", 64'(rvalid_b), 64'd1);
    check("lat_rd7_data",  bus_b,         64'h77);

    // Read-after-write to the same address must never show the old word.
    addr_b = 6'd3;
    tick(3);
    check("raw_pre_valid", 64'(rvalid_b), 64'd1);
    check("raw_pre_data",  bus_b,         64'h11);
    we_b = 1'b1; drv_b = 64'h22; den_b = 1'b1;
    #1;
    check("raw_wr_rvalid", 64'(rvalid_b), 64'd0);
    check("raw_wr_bus",    bus_b,         64'h22);
    tick(1);
    we_b = 1'b0; den_b = 1'b0;
    #1;
    check("raw_c0_rv", 64'(rvalid_b), 64'd0);
    tick(1);
    check("raw_c1_rv", 64'(rvalid_b), 64'd0);
    tick(1);
    check("raw_c2_rv", 64'(rvalid_b), 64'd0);
    tick(1);
    check("raw_valid", 64'(rvalid_b), 64'd1);
    check("raw_data",  bus_b,         64'h22);

    // Asynchronous reset mid-read releases the bus before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rvalid_b", 64'(rvalid_b), 64'd0);
    check("arst_bus_b",    bus_b,         BUS_IDLE);
    check("arst_rvalid_a", 64'(rvalid_a), 64'd0);
    check("arst_bus_a",    bus_a,         BUS_IDLE);
    check("arst_busy_a",   64'(busy_a),   64'(EXP_BUSY));
    tick(2);
    rst_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
